// File: rtl/qsv_pair_sequencer_if.sv
// rtl/qsv_pair_sequencer_if.sv - command and dual-port amplitude RAM bus for qsv_pair_sequencer
interface qsv_pair_sequencer_if #(
  parameter int NQ = 4,
  parameter int TW = 4
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [TW-1:0] cmd_target;
  logic          cmd_x;
  logic          cmd_z;
  logic          busy;
  logic          done;
  logic          err;
  logic          rd_en;
  logic [NQ-1:0] rd_addr0;
  logic [NQ-1:0] rd_addr1;
  logic [31:0]   rd_data0;
  logic [31:0]   rd_data1;
  logic          wr_en;
  logic [NQ-1:0] wr_addr0;
  logic [NQ-1:0] wr_addr1;
  logic [31:0]   wr_data0;
  logic [31:0]   wr_data1;

  modport slave (
    input  cmd_valid, cmd_target, cmd_x, cmd_z, rd_data0, rd_data1,
    output cmd_ready, busy, done, err, rd_en, rd_addr0, rd_addr1,
           wr_en, wr_addr0, wr_addr1, wr_data0, wr_data1
  );

  modport master (
    output cmd_valid, cmd_target, cmd_x, cmd_z, rd_data0, rd_data1,
    input  cmd_ready, busy, done, err, rd_en, rd_addr0, rd_addr1,
           wr_en, wr_addr0, wr_addr1, wr_data0, wr_data1
  );
endinterface

// File: rtl/qsv_pair_sequencer.sv
// rtl/qsv_pair_sequencer.sv - X/Z gate pair walker over a dual-port amplitude RAM
// Optional build macro QC_SEQ_SAT_EN: saturating Z negation (-(-32768) -> 32767).
module qsv_pair_sequencer #(
  parameter int NQ = 4,
  parameter int TW = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  qsv_pair_sequencer_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [NQ-2:0] r_c;
  logic [TW-1:0] r_target;
  logic          r_x;
  logic          r_z;
  logic          r_wr_vld;
  logic [NQ-1:0] r_wr_addr0;
  logic [NQ-1:0] r_wr_addr1;
  logic          r_done;
  logic          r_err;

  logic          w_accept;
  logic          w_tgt_ok;
  logic          w_rd_en;
  logic [NQ-1:0] w_c_ext;
  logic [NQ-1:0] w_mask;
  logic [NQ-1:0] w_addr0;
  logic [NQ-1:0] w_addr1;
  logic [31:0]   w_out0;
  logic [31:0]   w_out1;

  assign w_accept = (r_state == S_IDLE) && bus.cmd_valid;
  assign w_tgt_ok = 32'(bus.cmd_target) < NQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    case (r_state)
      S_IDLE:  if (w_accept && w_tgt_ok) w_next = S_RUN;
      S_RUN: begin
        w_rd_en = 1'b1;
        if (&r_c) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Pair address: insert a zero at bit 'target' of the counter, upper bits move up.
  always_comb begin
    w_c_ext = {1'b0, r_c};
    w_mask  = (NQ'(1) << r_target) - NQ'(1);
    w_addr0 = ((w_c_ext & ~w_mask) << 1) | (w_c_ext & w_mask);
    w_addr1 = w_addr0 | (NQ'(1) << r_target);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c        <= '0;
      r_target   <= '0;
      r_x        <= 1'b0;
      r_z        <= 1'b0;
      r_wr_vld   <= 1'b0;
      r_wr_addr0 <= '0;
      r_wr_addr1 <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_target <= bus.cmd_target;
        r_x      <= bus.cmd_x;
        r_z      <= bus.cmd_z;
        r_c      <= '0;
      end else if (r_state == S_RUN) begin
        r_c <= r_c + 1'b1;
      end
      r_err    <= w_accept && !w_tgt_ok;
      r_done   <= (r_state == S_DRAIN);
      r_wr_vld <= w_rd_en;
      if (w_rd_en) begin
        r_wr_addr0 <= w_addr0;
        r_wr_addr1 <= w_addr1;
      end
    end
  end

  function automatic logic [15:0] f_neg(input logic [15:0] v);
`ifdef QC_SEQ_SAT_EN
    return (v == 16'h8000) ? 16'h7fff : -v;
`else
    return -v;
`endif
  endfunction

  // X swaps first; Z then negates whatever lands in the i1 slot.
  always_comb begin
    w_out0 = r_x ? bus.rd_data1 : bus.rd_data0;
    w_out1 = r_x ? bus.rd_data0 : bus.rd_data1;
    if (r_z) w_out1 = {f_neg(w_out1[31:16]), f_neg(w_out1[15:0])};
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.rd_en     = w_rd_en;
  assign bus.rd_addr0  = w_rd_en ? w_addr0 : '0;
  assign bus.rd_addr1  = w_rd_en ? w_addr1 : '0;
  assign bus.wr_en     = r_wr_vld;
  assign bus.wr_addr0  = r_wr_addr0;
  assign bus.wr_addr1  = r_wr_addr1;
  assign bus.wr_data0  = r_wr_vld ? w_out0 : '0;
  assign bus.wr_data1  = r_wr_vld ? w_out1 : '0;
endmodule

// File: tb/tb_qsv_pair_sequencer.sv
// tb/tb_qsv_pair_sequencer.sv - directed scoreboard bench for qsv_pair_sequencer
module tb_qsv_pair_sequencer;
  localparam int NQ = 4;
  localparam int TW = 4;
  localparam int N  = 1 << NQ;
  localparam int P  = 1 << (NQ - 1);

  typedef struct {
    logic [NQ-1:0] a0;
    logic [NQ-1:0] a1;
    logic [31:0]   d0;
    logic [31:0]   d1;
  } wr_t;

  logic clk;
  logic rst_n;
  logic load;
  logic [31:0] ram [N];
  logic [31:0] img [N];
  logic [31:0] mdl [N];
  wr_t sbq [$];
  int vectors;
  int miscompares;

  qsv_pair_sequencer_if #(.NQ(NQ), .TW(TW)) bus ();

  qsv_pair_sequencer #(.NQ(NQ), .TW(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < N; k++) ram[k] <= img[k];
    end else begin
      if (bus.rd_en) begin
        bus.rd_data0 <= ram[bus.rd_addr0];
        bus.rd_data1 <= ram[bus.rd_addr1];
      end
      if (bus.wr_en) begin
        ram[bus.wr_addr0] <= bus.wr_data0;
        ram[bus.wr_addr1] <= bus.wr_data1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] neg16(input logic [15:0] v);
`ifdef QC_SEQ_SAT_EN
    if (v == 16'h8000) return 16'h7fff;
`endif
    return 16'(0 - int'(v));
  endfunction

  task automatic load_ram();
    for (int k = 0; k < N; k++) mdl[k] = img[k];
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Expected writes: ascending i with target bit clear, paired with i|bit.
  task automatic push_expected(input int t, input int x, input int z);
    wr_t e;
    logic [31:0] a, b;
    for (int i = 0; i < N; i++) begin
      if (((i >> t) & 1) == 0) begin
        a = mdl[i];
        b = mdl[i + (1 << t)];
        e.a0 = NQ'(i);
        e.a1 = NQ'(i + (1 << t));
        e.d0 = (x != 0) ? b : a;
        e.d1 = (x != 0) ? a : b;
        if (z != 0) e.d1 = {neg16(e.d1[31:16]), neg16(e.d1[15:0])};
        sbq.push_back(e);
        mdl[i] = e.d0;
        mdl[i + (1 << t)] = e.d1;
      end
    end
  endtask

  task automatic drive(input int t, input int x, input int z, input bit push);
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = TW'(t);
    bus.cmd_x      = x[0];
    bus.cmd_z      = z[0];
    if (push) push_expected(t, x, z);
  endtask

  task automatic check_write();
    wr_t e;
    if (sbq.size() == 0) begin
      chk("wr_unexpected", 64'(bus.wr_en), 64'd0);
    end else begin
      e = sbq.pop_front();
      chk("wr_addr0", 64'(bus.wr_addr0), 64'(e.a0));
      chk("wr_addr1", 64'(bus.wr_addr1), 64'(e.a1));
      chk("wr_data0", 64'(bus.wr_data0), 64'(e.d0));
      chk("wr_data1", 64'(bus.wr_data1), 64'(e.d1));
    end
  endtask

  task automatic run_cmd(input int t, input int x, input int z, input bit pre,
                         input bit chain, input int nt, input int nx, input int nz);
    if (!pre) begin
      @(negedge clk);
      drive(t, x, z, 1'b1);
    end
    @(posedge clk);
    for (int n = 1; n <= P + 2; n++) begin
      @(negedge clk);
      if (n == 1) bus.cmd_valid = 1'b0;
      chk($sformatf("rd_en_c%0d", n), 64'(bus.rd_en), 64'(n <= P));
      chk($sformatf("wr_en_c%0d", n), 64'(bus.wr_en), 64'(n >= 2 && n <= P + 1));
      chk($sformatf("done_c%0d", n), 64'(bus.done), 64'(n == P + 2));
      chk($sformatf("busy_c%0d", n), 64'(bus.busy), 64'(n <= P + 1));
      chk($sformatf("ready_c%0d", n), 64'(bus.cmd_ready), 64'(n == P + 2));
      if (bus.wr_en) check_write();
      if (n == P + 2 && chain) drive(nt, nx, nz, 1'b1);
    end
    if (!chain) begin
      @(negedge clk);
      chk("done_after", 64'(bus.done), 64'd0);
      chk("ready_after", 64'(bus.cmd_ready), 64'd1);
      chk("sb_drained", 64'(sbq.size()), 64'd0);
    end
  endtask

  task automatic check_ram_model(input string tag);
    for (int k = 0; k < N; k++) chk($sformatf("%s_ram%0d", tag, k), 64'(ram[k]), 64'(mdl[k]));
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    load = 1'b0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_target = '0;
    bus.cmd_x = 1'b0;
    bus.cmd_z = 1'b0;
    for (int k = 0; k < N; k++) img[k] = '0;

    @(negedge clk);
    chk("rst_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_rd_en", 64'(bus.rd_en), 64'd0);
    chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("rst_rd_addr1", 64'(bus.rd_addr1), 64'd0);
    chk("rst_wr_addr1", 64'(bus.wr_addr1), 64'd0);
    chk("rst_wr_data1", 64'(bus.wr_data1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // X on target 0 over a ramp
    for (int k = 0; k < N; k++) img[k] = {16'(k), 16'h0};
    load_ram();
    run_cmd(0, 1, 0, 1'b0, 1'b0, 0, 0, 0);
    chk("x_t0_ram0", 64'(ram[0]), 64'h0001_0000);
    chk("x_t0_ram1", 64'(ram[1]), 64'h0000_0000);
    check_ram_model("x_t0");

    // Z on target 3
    for (int k = 0; k < N; k++) img[k] = {16'd100, 16'hffce};
    load_ram();
    run_cmd(3, 0, 1, 1'b0, 1'b0, 0, 0, 0);
    for (int k = 0; k < N; k++)
      chk($sformatf("z_t3_ram%0d", k), 64'(ram[k]), (k < 8) ? 64'h0064_ffce : 64'hff9c_0032);

    // X+Z on target 1 chained back-to-back with an identity pass on target 2
    for (int k = 0; k < N; k++) img[k] = $urandom;
    img[0] = 32'h1000_0000;
    img[2] = 32'h2000_0100;
    load_ram();
    run_cmd(1, 1, 1, 1'b0, 1'b1, 2, 0, 0);
    run_cmd(2, 0, 0, 1'b1, 1'b0, 0, 0, 0);
    chk("xz_t1_ram0", 64'(ram[0]), 64'h2000_0100);
    chk("xz_t1_ram2", 64'(ram[2]), 64'hf000_0000);
    check_ram_model("xz_id");

    // Z on the most negative value
    for (int k = 0; k < N; k++) img[k] = '0;
    img[1] = 32'h8000_0000;
    load_ram();
    run_cmd(0, 0, 1, 1'b0, 1'b0, 0, 0, 0);
`ifdef QC_SEQ_SAT_EN
    chk("z_min_ram1", 64'(ram[1]), 64'h7fff_0000);
`else
    chk("z_min_ram1", 64'(ram[1]), 64'h8000_0000);
`endif
    chk("z_min_ram0", 64'(ram[0]), 64'h0);

    // Out-of-range target is rejected
    @(negedge clk);
    drive(5, 1, 1, 1'b0);
    @(posedge clk);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) bus.cmd_valid = 1'b0;
      chk($sformatf("rej_err_c%0d", n), 64'(bus.err), 64'(n == 1));
      chk($sformatf("rej_ready_c%0d", n), 64'(bus.cmd_ready), 64'd1);
      chk($sformatf("rej_rd_en_c%0d", n), 64'(bus.rd_en), 64'd0);
      chk($sformatf("rej_wr_en_c%0d", n), 64'(bus.wr_en), 64'd0);
    end

    // Reset in cycle 4 of a command
    for (int k = 0; k < N; k++) img[k] = $urandom;
    load_ram();
    @(negedge clk);
    drive(2, 1, 1, 1'b1);
    @(posedge clk);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      if (n == 1) bus.cmd_valid = 1'b0;
      chk($sformatf("ab_rd_en_c%0d", n), 64'(bus.rd_en), 64'd1);
      if (bus.wr_en) check_write();
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ab_rd_en", 64'(bus.rd_en), 64'd0);
    chk("ab_wr_en", 64'(bus.wr_en), 64'd0);
    chk("ab_busy", 64'(bus.busy), 64'd0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("ab_done_rst", 64'(bus.done), 64'd0);
      chk("ab_wr_en_rst", 64'(bus.wr_en), 64'd0);
    end
    rst_n = 1'b1;
    sbq.delete();
    for (int k = 0; k < N; k++) mdl[k] = ram[k];
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("ab_done_post", 64'(bus.done), 64'd0);
      chk("ab_ready_post", 64'(bus.cmd_ready), 64'd1);
      chk("ab_rd_en_post", 64'(bus.rd_en), 64'd0);
    end
    run_cmd(1, 1, 0, 1'b0, 1'b0, 0, 0, 0);
    check_ram_model("ab_rerun");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
